rx_chain_sequencer: RTL and testbench
=====================================

Name: rx_chain_sequencer

Overview:
- Control block for one RX decimation chain (NCO/CORDIC, CIC or integrator, halfband).
- Owns the chain's rate configuration from the serial bus and generates sample_strobe and decimator_strobe.
- Sequences chain enable and a one-cycle clear, then discards the post-start settling outputs before raising out_valid.
- Sits between the serial register bus and the chain instance; hb_strobe from the chain feeds back into it.

Parameters:
- RATEADDR, 2, serial address of the decimation-rate register (serial_data[7:0]).
- DIVADDR, 3, serial address of the sample-divider register (serial_data[7:0]).
- FLUSH_CNT, 8, number of hb_strobe pulses discarded after each start; range 0..255.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  chain run request, level.
- serial_addr  in  7  serial register address.
- serial_data  in  32  serial register data.
- serial_strobe  in  1  serial write qualifier.
- hb_strobe  in  1  output-valid strobe returned from the chain.
- chain_enable  out  1  enable to the chain.
- chain_reset  out  1  one-cycle synchronous clear pulse to the chain.
- sample_strobe  out  1  input-sample strobe to the chain.
- decimator_strobe  out  1  decimator-output strobe to the chain.
- decim_rate  out  8  registered decimation rate to the chain.
- out_valid  out  1  high when chain outputs are settled.
- seq_state  out  2  current state, for debug: IDLE=0, START=1, FLUSH=2, RUN=3.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; decim_rate=8'd1; divider register=0; all counters 0; every other output 0.
- Register writes:
  - serial_strobe && serial_addr==RATEADDR: decim_rate <= serial_data[7:0] on the next edge.
  - serial_strobe && serial_addr==DIVADDR: div_q <= serial_data[7:0].
  - Writes are accepted in every state.
  - Writes to any other address are ignored.
- IDLE:
  - chain_enable=0, chain_reset=0, both strobes=0, out_valid=0.
  - enable==1 sampled -> START.
- START (exactly 1 cycle):
  - chain_reset=1, chain_enable=0.
  - Load sample_ctr<=div_q and dec_ctr<=max(decim_rate,1)-1, using the registered values current in this cycle.
  - Load flush_ctr<=FLUSH_CNT.
  - Next state FLUSH; next state RUN directly if FLUSH_CNT==0.
- FLUSH / RUN:
  - chain_enable=1.
  - sample_strobe=1 when sample_ctr==0, then reload div_q; otherwise decrement. div_q==0 gives a strobe every cycle. The first strobe falls in FLUSH cycle index div_q (0-based).
  - decimator_strobe=sample_strobe && dec_ctr==0, then reload max(decim_rate,1)-1; else on sample_strobe decrement. decim_rate 0 or 1 gives a strobe on every sample_strobe.
  - Both strobes are registered outputs and single-cycle.
- FLUSH:
  - Each hb_strobe decrements flush_ctr.
  - An hb_strobe while flush_ctr==1 -> RUN next cycle.
  - out_valid=0.
- RUN: out_valid=1; hb_strobe is ignored.
- Rate change: an accepted write to RATEADDR or DIVADDR while in FLUSH or RUN -> START next cycle. The chain is re-cleared and re-flushed with the new values.
- enable==0 in any state -> IDLE next cycle. This takes priority over a simultaneous register write; the register is still updated.
- enable held high continuously: no restart occurs unless there is a config write.
- An hb_strobe arriving in IDLE or START is ignored.

Optional Feature:
- Macro: RX_SEQ_STATS_EN.
- Defined:
  - Adds output strobe_count [15:0], counting decimator_strobe pulses while out_valid==1.
  - Clears in START and on reset; wraps from 16'hFFFF to 0.
  - Adds output restart_count [7:0], counting config-triggered FLUSH/RUN->START transitions; saturates at 8'hFF; cleared only by reset.
- Undefined: neither port nor its counters exist. All other behaviour is identical.

Decomposition:
- Shared package rx_seq_pkg:
  - state encodings IDLE/START/FLUSH/RUN;
  - reset constants DECIM_RESET=8'd1, DIV_RESET=8'd0;
  - counter widths.
- One natural sub-module, strobe_divider: a reloadable down-counter with load, enable/tick input, reload value and a registered pulse output. It is instanced twice:
  - sample divider: tick = always 1 in FLUSH/RUN;
  - decimation divider: tick = sample_strobe.

Test Plan:
- Reset mid-RUN: drive reset low asynchronously -> all outputs 0 immediately, seq_state=0, decim_rate=1.
- div=3, rate=4, FLUSH_CNT=8, enable rises -> chain_reset is high exactly 1 cycle; sample_strobe every 4 cycles; decimator_strobe every 16 cycles; out_valid rises on the cycle after the 8th hb_strobe.
- div=0, rate=0 -> sample_strobe and decimator_strobe both high every cycle in FLUSH/RUN.
- Write rate=8 during RUN -> START next cycle (chain_reset pulse, out_valid=0); decimator_strobe every 8 sample_strobes after restart; 8 flush strobes required again.
- Same cycle: enable drops and a rate write occurs -> IDLE next cycle, no chain_reset; decim_rate shows the new value.
- With RX_SEQ_STATS_EN: 3 rate writes in RUN -> restart_count=3; strobe_count wraps 16'hFFFF->0 after 65536 valid decimator_strobes.

Source files
------------

// File: rtl/rx_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_seq_pkg
// Purpose  : Shared state codes, reset values and widths for rx_chain_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package rx_seq_pkg;

    localparam int c_CTR_W     = 8;
    localparam int c_FLUSH_W   = 8;
    localparam int c_STRB_W    = 16;
    localparam int c_RESTART_W = 8;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;
    localparam logic [1:0] c_RUN   = 2'd3;

    localparam logic [c_CTR_W-1:0] c_DECIM_RESET = 8'd1;
    localparam logic [c_CTR_W-1:0] c_DIV_RESET   = 8'd0;

    // A rate of 0 behaves like 1: one decimator strobe per sample strobe.
    function automatic logic [c_CTR_W-1:0] decim_reload(input logic [c_CTR_W-1:0] rate);
        return (rate == '0) ? '0 : rate - c_CTR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_chain_sequencer_strobe_divider.sv
`default_nettype none
// ============================================================================
// Module   : strobe_divider
// Purpose  : Reloadable down-counter producing a registered single-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
module strobe_divider #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_reload,
    input  logic             i_tick,
    output logic             o_pulse,
    output logic             o_fire
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cur;
    logic             r_pulse;

    // The count is evaluated one cycle ahead so the pulse itself can be a flop;
    // i_tick therefore means "the cycle after this one is a counting cycle".
    assign w_cur   = i_load ? i_reload : r_cnt;
    assign o_fire  = i_tick && (w_cur == '0);
    assign o_pulse = r_pulse;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= o_fire;
            if (!i_tick)
                r_cnt <= w_cur;
            else if (w_cur == '0)
                r_cnt <= i_reload;
            else
                r_cnt <= w_cur - WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rx_chain_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rx_chain_sequencer
// Purpose  : Rate configuration, strobe generation and start/flush sequencing
//            for one RX decimation chain. Define RX_SEQ_STATS_EN for counters.
// Revision : 1.0 - initial release
// ============================================================================
module rx_chain_sequencer
    import rx_seq_pkg::*;
#(
    parameter logic [6:0] RATEADDR  = 7'd2,
    parameter logic [6:0] DIVADDR   = 7'd3,
    parameter int         FLUSH_CNT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [6:0]  i_serial_addr,
    input  logic [31:0] i_serial_data,
    input  logic        i_serial_strobe,
    input  logic        i_hb_strobe,
`ifdef RX_SEQ_STATS_EN
    output logic [c_STRB_W-1:0]    o_strobe_count,
    output logic [c_RESTART_W-1:0] o_restart_count,
`endif
    output logic        o_chain_enable,
    output logic        o_chain_reset,
    output logic        o_sample_strobe,
    output logic        o_decimator_strobe,
    output logic [7:0]  o_decim_rate,
    output logic        o_out_valid,
    output logic [1:0]  o_seq_state
);

    localparam logic [c_FLUSH_W-1:0] c_FLUSH_INIT = c_FLUSH_W'(FLUSH_CNT);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [c_CTR_W-1:0]   r_decim_rate;
    logic [c_CTR_W-1:0]   r_div_q;
    logic [c_FLUSH_W-1:0] r_flush_ctr;
    logic w_rate_wr, w_div_wr, w_cfg_wr;
    logic w_active, w_next_active, w_start, w_restart;
    logic w_sample_fire, w_decim_fire_unused, w_data_hi_unused;

    assign w_rate_wr        = i_serial_strobe && (i_serial_addr == RATEADDR);
    assign w_div_wr         = i_serial_strobe && (i_serial_addr == DIVADDR);
    assign w_cfg_wr         = w_rate_wr || w_div_wr;
    assign w_active         = (r_state == c_FLUSH) || (r_state == c_RUN);
    assign w_next_active    = (w_state_next == c_FLUSH) || (w_state_next == c_RUN);
    assign w_start          = (r_state == c_START);
    assign w_restart        = i_enable && w_active && w_cfg_wr;
    assign w_data_hi_unused = ^i_serial_data[31:8];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_decim_rate <= c_DECIM_RESET;
            r_div_q      <= c_DIV_RESET;
        end else begin
            if (w_rate_wr) r_decim_rate <= i_serial_data[7:0];
            if (w_div_wr)  r_div_q      <= i_serial_data[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= c_IDLE;
        else          r_state <= w_state_next;
    end

    // Dropping enable wins over everything, including a restart-causing write.
    always_comb begin
        w_state_next = r_state;
        if (!i_enable) begin
            w_state_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  w_state_next = c_START;
                c_START: w_state_next = (FLUSH_CNT == 0) ? c_RUN : c_FLUSH;
                c_FLUSH: begin
                    if (w_cfg_wr)
                        w_state_next = c_START;
                    else if (i_hb_strobe && (r_flush_ctr == c_FLUSH_W'(1)))
                        w_state_next = c_RUN;
                end
                default: if (w_cfg_wr) w_state_next = c_START;
            endcase
        end
    end

    always_comb begin
        o_chain_enable = w_active;
        o_chain_reset  = w_start;
        o_out_valid    = (r_state == c_RUN);
        o_seq_state    = r_state;
        o_decim_rate   = r_decim_rate;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_flush_ctr <= '0;
        else if (w_start)
            r_flush_ctr <= c_FLUSH_INIT;
        else if ((r_state == c_FLUSH) && i_hb_strobe && (r_flush_ctr != '0))
            r_flush_ctr <= r_flush_ctr - c_FLUSH_W'(1);
    end

    strobe_divider #(.WIDTH(c_CTR_W)) u_sample_div (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_start),
        .i_reload (r_div_q),
        .i_tick   (w_next_active),
        .o_pulse  (o_sample_strobe),
        .o_fire   (w_sample_fire)
    );

    strobe_divider #(.WIDTH(c_CTR_W)) u_decim_div (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_start),
        .i_reload (decim_reload(r_decim_rate)),
        .i_tick   (w_sample_fire),
        .o_pulse  (o_decimator_strobe),
        .o_fire   (w_decim_fire_unused)
    );

`ifdef RX_SEQ_STATS_EN
    logic [c_STRB_W-1:0]    r_strobe_count;
    logic [c_RESTART_W-1:0] r_restart_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_strobe_count  <= '0;
            r_restart_count <= '0;
        end else begin
            if (w_start)
                r_strobe_count <= '0;
            else if (o_decimator_strobe && (r_state == c_RUN))
                r_strobe_count <= r_strobe_count + c_STRB_W'(1);
            if (w_restart && (r_restart_count != '1))
                r_restart_count <= r_restart_count + c_RESTART_W'(1);
        end
    end

    assign o_strobe_count  = r_strobe_count;
    assign o_restart_count = r_restart_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_chain_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_chain_sequencer
// Purpose  : Self-checking bench for rx_chain_sequencer against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_chain_sequencer;

    localparam int         F  = 8;
    localparam logic [6:0] RA = 7'd2;
    localparam logic [6:0] DA = 7'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en = 1'b0, sstrobe = 1'b0, hb = 1'b0;
    logic [6:0]  saddr = '0;
    logic [31:0] sdata = '0;

    logic       chain_en, chain_rst, samp, dec, valid;
    logic [7:0] rate;
    logic [1:0] st;
`ifdef RX_SEQ_STATS_EN
    logic [15:0] scount;
    logic [7:0]  rcount;
`endif

    rx_chain_sequencer #(.RATEADDR(RA), .DIVADDR(DA), .FLUSH_CNT(F)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_enable           (en),
        .i_serial_addr      (saddr),
        .i_serial_data      (sdata),
        .i_serial_strobe    (sstrobe),
        .i_hb_strobe        (hb),
`ifdef RX_SEQ_STATS_EN
        .o_strobe_count     (scount),
        .o_restart_count    (rcount),
`endif
        .o_chain_enable     (chain_en),
        .o_chain_reset      (chain_rst),
        .o_sample_strobe    (samp),
        .o_decimator_strobe (dec),
        .o_decim_rate       (rate),
        .o_out_valid        (valid),
        .o_seq_state        (st)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: phase 0..3 = IDLE/START/FLUSH/RUN; k = cycles since START.
    int m_phase, m_k, m_hbs, m_D, m_R, m_rate, m_div, m_scnt, m_rcnt;

    wire [14:0] obs = {chain_en, chain_rst, samp, dec, valid, st, rate};

    task automatic model_reset();
        m_phase = 0; m_k = 0; m_hbs = 0; m_D = 0; m_R = 1;
        m_rate = 1; m_div = 0; m_scnt = 0; m_rcnt = 0;
    endtask

    function automatic bit m_active();
        return (m_phase == 2) || (m_phase == 3);
    endfunction

    function automatic bit exp_samp();
        return m_active() && ((m_k % (m_D + 1)) == m_D);
    endfunction

    function automatic bit exp_dec();
        return exp_samp() && (((m_k / (m_D + 1)) % m_R) == (m_R - 1));
    endfunction

    function automatic logic [14:0] exp_vec();
        logic [1:0] ph;
        logic [7:0] r;
        ph = 2'(m_phase);
        r  = 8'(m_rate);
        return {m_active(), (m_phase == 1), exp_samp(), exp_dec(), (m_phase == 3), ph, r};
    endfunction

    // Apply one cycle of inputs, advance the model, then move past the edge.
    task automatic step(input logic e, input logic [6:0] a, input logic s,
                        input logic [31:0] d, input logic h);
        bit cfg;
        en = e; saddr = a; sstrobe = s; sdata = d; hb = h;
        cfg = s && ((a == RA) || (a == DA));
        if (m_phase == 1) m_scnt = 0;
        else if (m_phase == 3 && exp_dec()) m_scnt = (m_scnt + 1) % 65536;
        if (e && m_active() && cfg && m_rcnt < 255) m_rcnt++;
        if (!e) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: begin
                    m_D = m_div; m_R = (m_rate == 0) ? 1 : m_rate;
                    m_k = 0; m_hbs = 0;
                    m_phase = (F == 0) ? 3 : 2;
                end
                2: if (cfg) m_phase = 1;
                   else begin
                       m_k++;
                       if (h) begin
                           m_hbs++;
                           if (m_hbs == F) m_phase = 3;
                       end
                   end
                default: if (cfg) m_phase = 1; else m_k++;
            endcase
        end
        if (s && a == RA) m_rate = int'(d[7:0]);
        if (s && a == DA) m_div  = int'(d[7:0]);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_state: got %h exp %h", obs, exp_vec());
        end
`ifdef RX_SEQ_STATS_EN
        checks++;
        if ({scount, rcount} !== 24'd0) begin
            errors++; $display("FAIL reset_stats: got %h exp 0", {scount, rcount});
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_div3_rate4();
        step(0, DA, 1, 32'd3, 0);
        step(0, RA, 1, 32'd4, 0);
        for (int i = 0; i < 70; i++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL div3_rate4 cyc%0d: got %h exp %h", i, obs, exp_vec());
            end
            step(1, 0, 0, 0, ($urandom_range(0, 2) == 0));
        end
    endtask

    task automatic test_div0_rate0();
        step(0, 0, 0, 0, 0);
        step(0, DA, 1, 32'd0, 0);
        step(0, RA, 1, 32'hFFFF_FF00, 0);
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL div0_rate0 cyc%0d: got %h exp %h", i, obs, exp_vec());
            end
            step(1, 0, 0, 0, $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic test_restart();
        step(0, DA, 1, 32'd1, 0);
        for (int i = 0; i < 40 && m_phase != 3; i++) step(1, 0, 0, 0, 1);
        checks++;
        if (st !== 2'd3) begin
            errors++; $display("FAIL restart_reach_run: got %0d exp 3", st);
        end
        step(1, RA, 1, 32'd8, 0);
        checks++;
        if ({chain_rst, valid, st} !== {1'b1, 1'b0, 2'd1}) begin
            errors++; $display("FAIL restart_start: got %b exp 1001", {chain_rst, valid, st});
        end
        for (int i = 0; i < 90; i++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL restart cyc%0d: got %h exp %h", i, obs, exp_vec());
            end
            step(1, 0, 0, 0, ($urandom_range(0, 2) == 0));
        end
    endtask

    task automatic test_disable_write();
        for (int i = 0; i < 40 && m_phase != 3; i++) step(1, 0, 0, 0, 1);
        step(0, RA, 1, 32'd5, 0);
        checks++;
        if ({chain_rst, st, rate} !== {1'b0, 2'd0, 8'd5}) begin
            errors++; $display("FAIL disable_write: got %h exp 005", {chain_rst, st, rate});
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL disable_write_vec: got %h exp %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [6:0] oa;
            step(0, 0, 0, 0, 0);
            step(0, DA, 1, $urandom_range(0, 4), 0);
            step(0, RA, 1, $urandom_range(0, 5), 0);
            for (int i = 0; i < 110; i++) begin
                checks++;
                if (obs !== exp_vec()) begin
                    errors++; $display("FAIL random it%0d cyc%0d: got %h exp %h", it, i, obs, exp_vec());
                end
                oa = 7'($urandom_range(0, 127));
                if (oa == RA || oa == DA) oa = 7'd5;
                step(1, oa, ($urandom_range(0, 15) == 0), $urandom, $urandom_range(0, 1) == 1);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        step(0, RA, 1, 32'd3, 0);
        for (int i = 0; i < 40 && m_phase != 3; i++) step(1, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_mid_run: got %h exp %h", obs, exp_vec());
        end
        en = 1'b0; hb = 1'b0; sstrobe = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL after_reset: got %h exp %h", obs, exp_vec());
        end
    endtask

`ifdef RX_SEQ_STATS_EN
    task automatic test_stats();
        step(0, DA, 1, 32'd0, 0);
        step(0, RA, 1, 32'd0, 0);
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 40 && m_phase != 3; i++) step(1, 0, 0, 0, 1);
            step(1, RA, 1, 32'd0, 0);
        end
        for (int i = 0; i < 40 && m_phase != 3; i++) step(1, 0, 0, 0, 1);
        checks++;
        if (rcount !== 8'd3) begin
            errors++; $display("FAIL restart_count: got %0d exp 3", rcount);
        end
        for (int i = 0; i < 65545; i++) begin
            checks++;
            if (scount !== 16'(m_scnt)) begin
                errors++; $display("FAIL strobe_count cyc%0d: got %0d exp %0d", i, scount, m_scnt);
            end
            step(1, 0, 0, 0, 0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_div3_rate4();
        test_div0_rate0();
        test_restart();
        test_disable_write();
        test_random();
        test_reset_mid_run();
`ifdef RX_SEQ_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
